// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: instruction geometry,
// the HALT opcode and the fetch state encoding.
package fetch_stage_pkg;

    localparam int INSTR_W  = 20;
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_HALT   = 4'hF;
    localparam logic [INSTR_W-1:0]  NOP_INSTR = 20'h0;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN,
        ST_HALTED
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and the imem request/ready handshake,
// and feeds the IF/ID register, with stall skid, branch redirect/drain and HALT.
module fetch_stage #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 20,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instruction,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               valid,
    output logic               halted
);
    import fetch_stage_pkg::*;

    fetch_state_e        state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   drain_addr_q;
    logic [ADDR_W-1:0]   skid_pc_q;
    logic [INSTR_W-1:0]  skid_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [OPCODE_W-1:0] opcode_q;
    logic [ADDR_W-1:0]   pc_out_q;
    logic                valid_q;
    logic                halted_q;

    logic                complete;
    logic                deliver;
    logic                deliver_halt;
    logic                bubble;
    logic [INSTR_W-1:0]  deliver_word_d;
    logic [ADDR_W-1:0]   deliver_pc_d;

    // NOTE: imem_req is gated by reset so no request escapes in the reset cycle, whatever state_q holds.
    assign imem_req  = !reset && (state_q == ST_FETCH || state_q == ST_DRAIN);
    assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign complete  = imem_req && imem_ready;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        deliver_word_d = imem_data;
        deliver_pc_d   = pc_q;
        if (state_q == ST_HOLD) begin
            deliver_word_d = skid_q;
            deliver_pc_d   = skid_pc_q;
        end
        deliver = !branch_taken && !stall &&
                  ((state_q == ST_FETCH && complete) || state_q == ST_HOLD);
        deliver_halt = (deliver_word_d[INSTR_W-1 -: OPCODE_W] == OP_HALT);
        bubble = (state_q != ST_HALTED) &&
                 (branch_taken || state_q == ST_DRAIN ||
                  (state_q == ST_FETCH && !complete && !stall));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            instr_q      <= '0;
            opcode_q     <= '0;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            if (deliver) begin
                instr_q  <= deliver_word_d;
                opcode_q <= deliver_word_d[INSTR_W-1 -: OPCODE_W];
                pc_out_q <= deliver_pc_d;
                valid_q  <= 1'b1;
            end else if (bubble) begin
                instr_q  <= INSTR_W'(NOP_INSTR);
                opcode_q <= '0;
                valid_q  <= 1'b0;
            end else if (state_q == ST_HALTED) begin
                valid_q  <= 1'b0;
                halted_q <= 1'b1;
            end

            unique case (state_q)
                ST_FETCH: begin
                    if (branch_taken) begin
                        pc_q <= branch_target;
                        if (!complete) begin
                            drain_addr_q <= pc_q;
                            state_q      <= ST_DRAIN;
                        end
                    end else if (complete) begin
                        if (stall) begin
                            skid_q    <= imem_data;
                            skid_pc_q <= pc_q;
                            state_q   <= ST_HOLD;
                        end else if (deliver_halt) begin
                            state_q <= ST_HALTED;
                        end else begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (branch_taken) begin
                        pc_q    <= branch_target;
                        state_q <= ST_FETCH;
                    end else if (!stall) begin
                        if (deliver_halt) begin
                            state_q <= ST_HALTED;
                        end else begin
                            pc_q    <= skid_pc_q + 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The outstanding word is discarded; pc already holds the redirect target.
                    if (branch_taken) begin
                        pc_q <= branch_target;
                    end else if (complete) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_HALTED: begin
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign opcode      = opcode_q;
    assign pc_out      = pc_out_q;
    assign valid       = valid_q;
    assign halted      = halted_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage. It sits directly upstream of the IF/ID pipeline register and feeds it a 20-bit instruction, a 4-bit opcode, the instruction's PC and a valid flag each cycle. It owns the program counter and the request/ready handshake to instruction memory. It also handles stall hold-off, branch redirect/flush and HALT.

Parameters:
ADDR_W, 8, width of the word-addressed program counter and instruction memory address.
INSTR_W, 20, instruction width; opcode is instruction[INSTR_W-1:INSTR_W-4].
RESET_PC, 0, PC value loaded on reset.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hazard unit request: hold outputs unchanged this cycle.
branch_taken  input  1  single-cycle redirect pulse from the execute stage.
branch_target  input  ADDR_W  new PC, valid when branch_taken=1.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  ADDR_W  word address of the request.
imem_ready  input  1  memory has the word on imem_data; may be high in the same cycle as imem_req.
imem_data  input  INSTR_W  fetched word, valid when imem_req & imem_ready.
instruction  output  INSTR_W  registered instruction to IF/ID.
opcode  output  4  registered copy of instruction[19:16].
pc_out  output  ADDR_W  address of the instruction currently presented.
valid  output  1  instruction/opcode/pc_out carry a real instruction; 0 means bubble.
halted  output  1  fetch has stopped after delivering HALT.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - pc=RESET_PC, state=FETCH.
  - instruction=0, opcode=0, pc_out=0, valid=0, halted=0, skid buffer cleared.
  - imem_req=0 in the reset cycle.
- Priority each cycle: reset > branch_taken > stall > normal progress.
- A transaction completes in any cycle with imem_req=1 and imem_ready=1. imem_addr is stable while imem_req is high and not yet ready.
- State FETCH (imem_req=1, imem_addr=pc):
  - Complete and !stall: outputs <= {imem_data, imem_data[19:16], pc, valid=1}; pc <= pc+1; stay in FETCH. This gives back-to-back issue.
  - Complete and stall: outputs held; skid <= imem_data; skid_pc <= pc; go to HOLD.
  - Not complete and !stall: outputs <= bubble (instruction=0, opcode=0, valid=0; pc_out unchanged).
  - Not complete and stall: outputs held.
- State HOLD (imem_req=0):
  - stall=1: outputs held.
  - stall=0: outputs <= skid contents with valid=1; pc <= skid_pc+1; go to FETCH.
- State DRAIN (imem_req=1, imem_addr=drain_addr):
  - Waits for the outstanding request to complete; the returned word is discarded.
  - Then go to FETCH at the already-redirected pc. Outputs are bubbles.
- State HALTED: imem_req=0, halted=1, outputs hold the HALT instruction with valid=0. Only reset exits.
- HALT: delivering a word with opcode 4'hF (from FETCH or HOLD) sets the outputs with valid=1 for that cycle. Next state is HALTED; pc is not incremented.
- branch_taken (ignored in HALTED):
  - pc <= branch_target; outputs <= bubble next cycle, even if stall=1; skid discarded.
  - In FETCH with completion this cycle: data dropped, stay in FETCH.
  - In FETCH without completion: drain_addr <= old pc, go to DRAIN.
  - In HOLD: go to FETCH.
  - In DRAIN: pc retargeted, stay in DRAIN.
- Arithmetic: pc+1 wraps modulo 2^ADDR_W (0xFF -> 0x00 at the default width).
- Latency: with zero-wait memory, the word requested in cycle N appears on the outputs at N+1.

Decomposition:
- Shared pipeline package: INSTR_W=20, OPCODE_W=4, OP_HALT=4'hF, NOP_INSTR=20'h0, fetch state encoding (FETCH, HOLD, DRAIN, HALTED).
- Single module; the skid buffer is small enough to stay inline. No sub-module.

Test Plan:
- Zero-wait memory, imem_data=addr-tagged words, no stall -> valid=1 every cycle from the 2nd cycle after reset, pc_out 0,1,2,3...
- imem_ready low for 3 cycles at pc=4 -> 3 bubble cycles (valid=0, instruction=0), then word 4 with pc_out=4; imem_addr stays 4 throughout.
- stall held 2 cycles while word 5 completes -> outputs frozen on word 4, imem_req=0 in HOLD, then word 5 appears and the fetch of 6 follows.
- branch_taken (target 0x20) while a request to 7 is pending -> DRAIN until ready, word 7 never appears, next valid output has pc_out=0x20.
- pc at 0xFF, stream continues -> pc_out 0xFF followed by 0x00.
- HALT word (0xF0000) at address 3 -> delivered once with valid=1, then halted=1, imem_req=0, branch_taken ignored; reset mid-HALT restores pc=0 and valid=0 the next cycle.
